// File: rtl/fetch_pkg.sv
// Shared definitions for the RV32I instruction fetch stage.
//   fetch_state_e : fetch FSM states (request outstanding / holding a stalled word)
//   NOP_INSTR     : ADDI x0,x0,0, loaded into IF/ID whenever it carries a bubble
//   PC_STEP       : sequential PC increment in bytes
package fetch_pkg;

  typedef enum logic [0:0] {
    StReq  = 1'b0,
    StHold = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select for the fetch stage.
//   pc_i        : current fetch PC
//   branch_pc_i : PC of the redirecting instruction in execute
//   imm_i       : sign-extended branch/jump offset
//   redirect_i  : select the branch target instead of the sequential PC
//   next_pc_o   : pc_i + 4, or (branch_pc_i + imm_i) with bit 0 cleared
// All arithmetic wraps modulo 2^AddrWidth; the offset is two's complement.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned AddrWidth = 32
) (
  input  logic [AddrWidth-1:0] pc_i,
  input  logic [AddrWidth-1:0] branch_pc_i,
  input  logic [AddrWidth-1:0] imm_i,
  input  logic                 redirect_i,
  output logic [AddrWidth-1:0] next_pc_o
);

  logic [AddrWidth-1:0] seq_pc;
  logic [AddrWidth-1:0] target;

  always_comb begin
    seq_pc    = pc_i + AddrWidth'(PC_STEP);
    target    = branch_pc_i + imm_i;
    // JALR semantics: the target LSB is always forced to zero.
    target[0] = 1'b0;
    next_pc_o = redirect_i ? target : seq_pc;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC register, instruction-memory handshake and IF/ID register.
//   clk, rst             : clock and synchronous active-high reset
//   imem_req/imem_addr   : request and address, held stable until imem_ack
//   imem_ack/imem_rdata  : memory response, data valid while imem_ack=1
//   stall                : decode cannot accept a new instruction
//   redirect             : taken branch/jump; target = branch_pc + ImmOp, bit 0 cleared
//   instr/pc_id/valid_id : IF/ID register towards sign_extend and the decoder
// At most one request is outstanding. A redirect while a request is in flight moves the PC
// immediately but keeps the old address on the bus and drops the stale response (discard).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned              address_width = 32,
  parameter logic [address_width-1:0] RESET_VECTOR  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [address_width-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [address_width-1:0] imem_rdata,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [address_width-1:0] branch_pc,
  input  logic [address_width-1:0] ImmOp,
  output logic [address_width-1:0] instr,
  output logic [address_width-1:0] pc_id,
  output logic                     valid_id
);

  localparam logic [address_width-1:0] Nop = address_width'(NOP_INSTR);

  fetch_state_e             state_q, state_d;
  logic [address_width-1:0] pc_q, pc_d;
  logic [address_width-1:0] req_addr_q, req_addr_d;
  logic                     pend_q, pend_d;
  logic                     discard_q, discard_d;
  logic [address_width-1:0] hold_instr_q, hold_instr_d;
  logic [address_width-1:0] hold_pc_q, hold_pc_d;
  logic [address_width-1:0] instr_q, instr_d;
  logic [address_width-1:0] pc_id_q, pc_id_d;
  logic                     valid_id_q, valid_id_d;
  logic [address_width-1:0] next_pc;
  logic                     ack;

  pc_next #(
    .AddrWidth (address_width)
  ) u_pc_next (
    .pc_i        (pc_q),
    .branch_pc_i (branch_pc),
    .imm_i       (ImmOp),
    .redirect_i  (redirect),
    .next_pc_o   (next_pc)
  );

  // The first cycle of a request drives pc directly so a zero-latency memory can ack at once;
  // from the second cycle on the latched address is used, which survives a redirect of pc.
  assign imem_req  = (state_q == StReq) && !rst;
  assign imem_addr = pend_q ? req_addr_q : pc_q;
  assign ack       = imem_req && imem_ack;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    pend_d       = pend_q;
    discard_d    = discard_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    instr_d      = instr_q;
    pc_id_d      = pc_id_q;
    valid_id_d   = valid_id_q;

    unique case (state_q)
      StReq: begin
        if (ack) begin
          pend_d = 1'b0;
          if (redirect) begin
            pc_d      = next_pc;
            discard_d = 1'b0;
          end else if (discard_q) begin
            // Stale response for an address abandoned by an earlier redirect.
            discard_d = 1'b0;
          end else if (stall) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            pc_d         = next_pc;
            state_d      = StHold;
          end else begin
            instr_d    = imem_rdata;
            pc_id_d    = pc_q;
            valid_id_d = 1'b1;
            pc_d       = next_pc;
          end
        end else begin
          pend_d     = 1'b1;
          req_addr_d = imem_addr;
          if (redirect) begin
            pc_d      = next_pc;
            discard_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = StReq;
        end else if (!stall) begin
          instr_d    = hold_instr_q;
          pc_id_d    = hold_pc_q;
          valid_id_d = 1'b1;
          state_d    = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    // Redirect beats stall: IF/ID always becomes a bubble.
    if (redirect) begin
      instr_d    = Nop;
      valid_id_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      pc_q         <= RESET_VECTOR;
      req_addr_q   <= RESET_VECTOR;
      pend_q       <= 1'b0;
      discard_q    <= 1'b0;
      hold_instr_q <= Nop;
      hold_pc_q    <= '0;
      instr_q      <= Nop;
      pc_id_q      <= '0;
      valid_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      pend_q       <= pend_d;
      discard_q    <= discard_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      instr_q      <= instr_d;
      pc_id_q      <= pc_id_d;
      valid_id_q   <= valid_id_d;
    end
  end

  assign instr    = instr_q;
  assign pc_id    = pc_id_q;
  assign valid_id = valid_id_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the RV32I core. It sits directly upstream of sign_extend and the decoder, and owns the PC register, the instruction-memory request handshake and the IF/ID register. The IF/ID register drives `instr` to sign_extend and the control unit. PC redirects from execute use the branch base PC plus the ImmOp that sign_extend produces.

Parameters:
address_width, 32, width of PC, memory address and instruction word
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_req  out  1  instruction memory request
imem_addr  out  address_width  fetch address (current PC)
imem_ack  in  1  memory returns data this cycle
imem_rdata  in  address_width  instruction word, valid when imem_ack=1
stall  in  1  decode cannot accept a new instruction
redirect  in  1  taken branch or jump from execute
branch_pc  in  address_width  PC of the redirecting instruction
ImmOp  in  address_width  sign-extended offset from sign_extend
instr  out  address_width  IF/ID instruction to sign_extend and the decoder
pc_id  out  address_width  PC of instr
valid_id  out  1  instr is a real instruction (0 = bubble)

Behaviour:
- Reset (rst=1 at an edge):
  - pc <= RESET_VECTOR; state <= REQ; discard <= 0.
  - instr <= 32'h0000_0013 (NOP); pc_id <= 0; valid_id <= 0.
  - imem_req = 0 while rst=1.
  - Reset mid-request abandons the request; a late imem_ack arriving after reset is ignored only if it arrives while discard=1, otherwise it is accepted as the reset-vector fetch.
- State REQ:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - One outstanding request only.
- imem_ack in REQ with discard=0, stall=0, redirect=0:
  - instr <= imem_rdata; pc_id <= pc; valid_id <= 1; pc <= pc+4; stay REQ.
  - Next request issues the following cycle.
  - Best throughput is 1 instruction per cycle when memory acks in the same cycle as the request (combinational memory).
- imem_ack in REQ with stall=1, redirect=0:
  - Capture imem_rdata and pc into the hold register; pc <= pc+4; go HOLD.
  - IF/ID unchanged.
- State HOLD:
  - imem_req=0.
  - When stall=0: instr <= hold instr; pc_id <= hold pc; valid_id <= 1; go REQ.
- Stall with no new data:
  - IF/ID (instr, pc_id, valid_id) holds its value whenever stall=1, in any state.
- Redirect (redirect=1), takes priority over stall:
  - target = (branch_pc + ImmOp) with bit 0 forced to 0, modulo 2^address_width.
  - valid_id <= 0; instr <= NOP.
  - In REQ with imem_ack=1 or in HOLD: pc <= target; go REQ; the held or returning instruction is dropped.
  - In REQ with imem_ack=0: pc <= target and discard <= 1; imem_addr stays at the old pc until ack.
  - The old address is captured into a req_addr register at issue, so imem_addr is driven from req_addr, not pc.
- discard:
  - When ack arrives with discard=1: data dropped, discard <= 0, pc unchanged (already target), stay REQ.
  - A new redirect while discard=1 simply overwrites pc.
- Arithmetic:
  - pc+4 wraps at 2^address_width: 0xFFFF_FFFC -> 0x0000_0000.
  - ImmOp is treated as two's complement; no overflow flag.
- stall and redirect both high: redirect wins, IF/ID becomes bubble; stall still blocks decode consuming it, which is harmless.

Decomposition:
- fetch_pkg:
  - state enum {REQ, HOLD}.
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 4.
- One sub-module, pc_next: combinational next-PC select (pc+4 / target, bit-0 clear).
- Instantiated once; FSM, hold register and IF/ID register stay in fetch_stage.

Test Plan:
- Reset then zero-latency memory, stall=0:
  - instr at 0x0,0x4,0x8 appear on consecutive cycles.
  - pc_id 0,4,8; valid_id=1 from the first ack.
- Memory ack delayed 2 cycles:
  - imem_addr=0x4 held stable 3 cycles; valid_id for 0x4 rises only after the ack.
  - IF/ID holds the 0x0 instruction throughout.
- Stall during ack at pc=0x8:
  - HOLD entered, imem_req=0.
  - Stall released after 3 cycles -> instr=data@0x8, pc_id=0x8; next request addr=0xC.
- Redirect with branch_pc=0x10, ImmOp=0xFFFF_FFF8 while a request to 0x14 is outstanding:
  - ack data dropped, valid_id=0.
  - Next request addr=0x8, then pc_id=0x8.
- Redirect and stall together in HOLD, target 0x100:
  - held instruction dropped; next imem_addr=0x100; valid_id=0.
- rst asserted mid-request at pc=0x20:
  - next cycle instr=0x13, valid_id=0, imem_req=0.
  - After release imem_addr=RESET_VECTOR.
  - Wrap check: RESET_VECTOR=0xFFFF_FFFC -> second fetch addr=0x0.
